// File: rtl/cu_fsm.sv
// cu_fsm: multicycle sequencer for the MCU core.
// Steps each instruction through FETCH, EXEC and an optional load WB state,
// and inserts an INTR cycle at an instruction boundary when INTR is high.
// Outputs are combinational from state, OPCODE and FUNC3. RST masks all of them.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   INTR       level interrupt request (already enable-gated upstream)
//   OPCODE     ir[6:0]
//   FUNC3      ir[14:12]
//   PC_WE      program counter write enable
//   RF_WE      register file write enable
//   MEM_WE2    data memory write enable
//   MEM_RDEN1  instruction memory read enable
//   MEM_RDEN2  data memory read enable
//   CSR_WE     CSR file write enable
//   INT_TAKEN  interrupt entry strobe
//   MRET_EXEC  mret strobe
//   RST_PC     resets PC and CSR file
//   STATE      current state code, for debug
module cu_fsm #(
  parameter int MEM_LAT = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       INTR,
  input  logic [6:0] OPCODE,
  input  logic [2:0] FUNC3,
  output logic       PC_WE,
  output logic       RF_WE,
  output logic       MEM_WE2,
  output logic       MEM_RDEN1,
  output logic       MEM_RDEN2,
  output logic       CSR_WE,
  output logic       INT_TAKEN,
  output logic       MRET_EXEC,
  output logic       RST_PC,
  output logic [2:0] STATE
);

  localparam int CW = $clog2(MEM_LAT + 1);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

  state_t        state;
  state_t        next;
  logic [CW-1:0] cnt;

  // Raw strobes before reset masking.
  logic pc_we, rf_we, mem_we2, mem_rden1, mem_rden2, csr_we, int_taken, mret_exec, rst_pc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_INIT;
    end else begin
      state <= next;
    end
  end

  // Counter idles at zero outside FETCH, which gives the clear-on-entry.
  always_ff @(posedge CLK) begin
    if (RST || state != ST_FETCH) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    next      = ST_INIT;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    mem_we2   = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    csr_we    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    rst_pc    = 1'b0;

    case (state)
      ST_INIT: begin
        rst_pc = 1'b1;
        next   = ST_FETCH;
      end

      ST_FETCH: begin
        mem_rden1 = 1'b1;
        next      = (cnt == CW'(MEM_LAT - 1)) ? ST_EXEC : ST_FETCH;
      end

      ST_EXEC: begin
        case (OPCODE)
          OP_RTYPE, OP_IALU, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
            pc_we = 1'b1;
            rf_we = 1'b1;
          end
          OP_LOAD: begin
            mem_rden2 = 1'b1;
          end
          OP_STORE: begin
            pc_we   = 1'b1;
            mem_we2 = 1'b1;
          end
          OP_SYSTEM: begin
            pc_we = 1'b1;
            if (FUNC3 == 3'b000) begin
              mret_exec = 1'b1;
            end else begin
              rf_we  = 1'b1;
              csr_we = 1'b1;
            end
          end
          default: begin
            // Branches and unknown opcodes only advance the PC.
            pc_we = 1'b1;
          end
        endcase

        if (OPCODE == OP_LOAD) begin
          next = ST_WB;
        end else if (INTR) begin
          next = ST_INTR;
        end else begin
          next = ST_FETCH;
        end
      end

      ST_WB: begin
        pc_we = 1'b1;
        rf_we = 1'b1;
        next  = INTR ? ST_INTR : ST_FETCH;
      end

      ST_INTR: begin
        int_taken = 1'b1;
        pc_we     = 1'b1;
        next      = ST_FETCH;
      end

      default: begin
        next = ST_INIT;
      end
    endcase
  end

  assign PC_WE     = pc_we     & ~RST;
  assign RF_WE     = rf_we     & ~RST;
  assign MEM_WE2   = mem_we2   & ~RST;
  assign MEM_RDEN1 = mem_rden1 & ~RST;
  assign MEM_RDEN2 = mem_rden2 & ~RST;
  assign CSR_WE    = csr_we    & ~RST;
  assign INT_TAKEN = int_taken & ~RST;
  assign MRET_EXEC = mret_exec & ~RST;
  assign RST_PC    = rst_pc    & ~RST;
  assign STATE     = state;

endmodule

// File: tb/tb_cu_fsm.sv
// Self-checking bench for cu_fsm: one instance with MEM_LAT=1 and one with
// MEM_LAT=3 share the stimulus. Each vector is one clock cycle: inputs are
// driven just after the falling edge and outputs are checked before the
// next rising edge.
module tb_cu_fsm;

  localparam logic [8:0] S_PC   = 9'h100;
  localparam logic [8:0] S_RF   = 9'h080;
  localparam logic [8:0] S_MWE  = 9'h040;
  localparam logic [8:0] S_RD1  = 9'h020;
  localparam logic [8:0] S_RD2  = 9'h010;
  localparam logic [8:0] S_CSR  = 9'h008;
  localparam logic [8:0] S_INT  = 9'h004;
  localparam logic [8:0] S_MRET = 9'h002;
  localparam logic [8:0] S_RPC  = 9'h001;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] SYS = 7'b1110011;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct {
    logic       rst;
    logic       intr;
    logic [6:0] op;
    logic [2:0] f3;
    logic [2:0] st;
    logic [8:0] str;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, intr;
  logic [6:0] opcode;
  logic [2:0] func3;

  logic       a_pc, a_rf, a_mwe, a_rd1, a_rd2, a_csr, a_int, a_mret, a_rpc;
  logic       b_pc, b_rf, b_mwe, b_rd1, b_rd2, b_csr, b_int, b_mret, b_rpc;
  logic [2:0] a_st, b_st;

  int checks = 0;
  int errors = 0;

  vec_t t1[$];
  vec_t t3[$];

  always #5 clk = ~clk;

  cu_fsm #(.MEM_LAT(1)) dut1 (
    .CLK(clk), .RST(rst), .INTR(intr), .OPCODE(opcode), .FUNC3(func3),
    .PC_WE(a_pc), .RF_WE(a_rf), .MEM_WE2(a_mwe), .MEM_RDEN1(a_rd1),
    .MEM_RDEN2(a_rd2), .CSR_WE(a_csr), .INT_TAKEN(a_int),
    .MRET_EXEC(a_mret), .RST_PC(a_rpc), .STATE(a_st)
  );

  cu_fsm #(.MEM_LAT(3)) dut3 (
    .CLK(clk), .RST(rst), .INTR(intr), .OPCODE(opcode), .FUNC3(func3),
    .PC_WE(b_pc), .RF_WE(b_rf), .MEM_WE2(b_mwe), .MEM_RDEN1(b_rd1),
    .MEM_RDEN2(b_rd2), .CSR_WE(b_csr), .INT_TAKEN(b_int),
    .MRET_EXEC(b_mret), .RST_PC(b_rpc), .STATE(b_st)
  );

  wire [8:0] a_str = {a_pc, a_rf, a_mwe, a_rd1, a_rd2, a_csr, a_int, a_mret, a_rpc};
  wire [8:0] b_str = {b_pc, b_rf, b_mwe, b_rd1, b_rd2, b_csr, b_int, b_mret, b_rpc};

  task automatic add1(input logic r, input logic i, input logic [6:0] o,
                      input logic [2:0] f, input logic [2:0] s, input logic [8:0] x);
    vec_t v;
    v.rst = r; v.intr = i; v.op = o; v.f3 = f; v.st = s; v.str = x;
    t1.push_back(v);
  endtask

  task automatic add3(input logic r, input logic i, input logic [6:0] o,
                      input logic [2:0] f, input logic [2:0] s, input logic [8:0] x);
    vec_t v;
    v.rst = r; v.intr = i; v.op = o; v.f3 = f; v.st = s; v.str = x;
    t3.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [2:0] got_st, input logic [8:0] got_str,
                       input logic [2:0] exp_st, input logic [8:0] exp_str);
    checks++;
    if (got_st !== exp_st || got_str !== exp_str) begin
      errors++;
      $display("FAIL %s[%0d]: state got %0d want %0d, strobes got %b want %b",
               name, idx, got_st, exp_st, got_str, exp_str);
    end
  endtask

  initial begin
    rst = 1'b1; intr = 1'b0; opcode = R; func3 = 3'b000;

    // MEM_LAT=1 instance: reset, R-type, load, store+intr, mret+intr,
    // LUI, unknown opcode, lost intr pulse, load+intr in WB, reset in WB, CSR op.
    add1(1, 0, R,   0, 0, '0);
    add1(1, 0, R,   0, 0, '0);
    add1(0, 0, R,   0, 0, S_RPC);
    add1(0, 0, R,   0, 1, S_RD1);
    add1(0, 0, R,   0, 2, S_PC | S_RF);
    add1(0, 0, R,   0, 1, S_RD1);
    add1(0, 0, R,   0, 2, S_PC | S_RF);
    add1(0, 0, LD,  0, 1, S_RD1);
    add1(0, 0, LD,  0, 2, S_RD2);
    add1(0, 0, LD,  0, 3, S_PC | S_RF);
    add1(0, 1, ST,  0, 1, S_RD1);
    add1(0, 1, ST,  0, 2, S_PC | S_MWE);
    add1(0, 1, ST,  0, 4, S_PC | S_INT);
    add1(0, 0, SYS, 0, 1, S_RD1);
    add1(0, 1, SYS, 0, 2, S_PC | S_MRET);
    add1(0, 0, SYS, 0, 4, S_PC | S_INT);
    add1(0, 0, LUI, 0, 1, S_RD1);
    add1(0, 0, LUI, 0, 2, S_PC | S_RF);
    add1(0, 0, BAD, 0, 1, S_RD1);
    add1(0, 0, BAD, 0, 2, S_PC);
    add1(0, 1, LD,  0, 1, S_RD1);
    add1(0, 0, LD,  0, 2, S_RD2);
    add1(0, 0, LD,  0, 3, S_PC | S_RF);
    add1(0, 1, LD,  0, 1, S_RD1);
    add1(0, 1, LD,  0, 2, S_RD2);
    add1(0, 1, LD,  0, 3, S_PC | S_RF);
    add1(0, 0, LD,  0, 4, S_PC | S_INT);
    add1(0, 0, LD,  0, 1, S_RD1);
    add1(0, 0, LD,  0, 2, S_RD2);
    add1(1, 0, LD,  0, 3, '0);
    add1(0, 0, LD,  0, 0, S_RPC);
    add1(0, 0, SYS, 1, 1, S_RD1);
    add1(0, 0, SYS, 1, 2, S_PC | S_RF | S_CSR);
    add1(0, 0, SYS, 1, 1, S_RD1);

    // MEM_LAT=3 instance: three-cycle fetch, mret, then a CSR op.
    add3(1, 0, SYS, 0, 0, '0);
    add3(0, 0, SYS, 0, 0, S_RPC);
    add3(0, 0, SYS, 0, 1, S_RD1);
    add3(0, 0, SYS, 0, 1, S_RD1);
    add3(0, 0, SYS, 0, 1, S_RD1);
    add3(0, 0, SYS, 0, 2, S_PC | S_MRET);
    add3(0, 0, SYS, 1, 1, S_RD1);
    add3(0, 0, SYS, 1, 1, S_RD1);
    add3(0, 0, SYS, 1, 1, S_RD1);
    add3(0, 0, SYS, 1, 2, S_PC | S_RF | S_CSR);
    add3(0, 0, SYS, 1, 1, S_RD1);

    for (int i = 0; i < t1.size(); i++) begin
      @(negedge clk);
      rst = t1[i].rst; intr = t1[i].intr; opcode = t1[i].op; func3 = t1[i].f3;
      #2;
      check("lat1", i, a_st, a_str, t1[i].st, t1[i].str);
    end

    // Unchecked reset edge so the MEM_LAT=3 instance starts from INIT.
    @(negedge clk);
    rst = 1'b1; intr = 1'b0;

    for (int i = 0; i < t3.size(); i++) begin
      @(negedge clk);
      rst = t3[i].rst; intr = t3[i].intr; opcode = t3[i].op; func3 = t3[i].f3;
      #2;
      check("lat3", i, b_st, b_str, t3[i].st, t3[i].str);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
